slot_dispatcher: RTL and testbench

- Consumer side of the DMA slot table. Walks every slot in index order and reads each descriptor through the table's combinational read port.
- For each PENDING slot, issues an MM2S read command and an S2MM write command, then waits for both completions.
- Writes back status=DONE and the measured cycle count through the table's status and profile write strobes.
- Sits between the slot table and the DMA command interfaces of the reconfiguration sequencer.

---
 rtl/slot_dispatcher_pkg.sv | 18 +
 rtl/slot_dispatcher_if.sv | 53 +++++
 rtl/slot_dispatcher_dma_cmd_chan.sv | 51 +++++
 rtl/slot_dispatcher.sv | 129 ++++++++++++
 tb/tb_slot_dispatcher.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/slot_dispatcher_pkg.sv
// Shared encodings for the slot dispatcher: descriptor status values and FSM states.
package slot_dispatcher_pkg;

  localparam logic [1:0] ST_EMPTY   = 2'b00;
  localparam logic [1:0] ST_PENDING = 2'b01;
  localparam logic [1:0] ST_DONE    = 2'b10;
  localparam logic [1:0] ST_RSVD    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_WB,
    S_NEXT
  } state_t;

endpackage

// File: rtl/slot_dispatcher_if.sv
// Slot-table read/write ports and the MM2S/S2MM command channels seen by the dispatcher.
interface slot_dispatcher_if #(
  parameter int INDEX_WIDTH    = 2,
  parameter int SRC_ADDR_WIDTH = 32,
  parameter int SRC_SIZE_WIDTH = 26,
  parameter int DST_ADDR_WIDTH = 32,
  parameter int DST_SIZE_WIDTH = 26,
  parameter int STATUS_WIDTH   = 2,
  parameter int PROFILE_WIDTH  = 32
);

  logic [INDEX_WIDTH-1:0]    rd_index;
  logic [SRC_ADDR_WIDTH-1:0] rd_src_addr;
  logic [SRC_SIZE_WIDTH-1:0] rd_src_size;
  logic [DST_ADDR_WIDTH-1:0] rd_des_addr;
  logic [DST_SIZE_WIDTH-1:0] rd_des_size;
  logic [STATUS_WIDTH-1:0]   rd_status;

  logic [INDEX_WIDTH-1:0]    wr_index;
  logic [STATUS_WIDTH-1:0]   wr_status;
  logic [PROFILE_WIDTH-1:0]  wr_profile;
  logic                      set_status;
  logic                      set_profile;

  logic                      mm2s_cmd_valid;
  logic                      mm2s_cmd_ready;
  logic [SRC_ADDR_WIDTH-1:0] mm2s_cmd_addr;
  logic [SRC_SIZE_WIDTH-1:0] mm2s_cmd_size;
  logic                      mm2s_done;

  logic                      s2mm_cmd_valid;
  logic                      s2mm_cmd_ready;
  logic [DST_ADDR_WIDTH-1:0] s2mm_cmd_addr;
  logic [DST_SIZE_WIDTH-1:0] s2mm_cmd_size;
  logic                      s2mm_done;

  modport master (
    output rd_index, wr_index, wr_status, wr_profile, set_status, set_profile,
           mm2s_cmd_valid, mm2s_cmd_addr, mm2s_cmd_size,
           s2mm_cmd_valid, s2mm_cmd_addr, s2mm_cmd_size,
    input  rd_src_addr, rd_src_size, rd_des_addr, rd_des_size, rd_status,
           mm2s_cmd_ready, mm2s_done, s2mm_cmd_ready, s2mm_done
  );

  modport slave (
    input  rd_index, wr_index, wr_status, wr_profile, set_status, set_profile,
           mm2s_cmd_valid, mm2s_cmd_addr, mm2s_cmd_size,
           s2mm_cmd_valid, s2mm_cmd_addr, s2mm_cmd_size,
    output rd_src_addr, rd_src_size, rd_des_addr, rd_des_size, rd_status,
           mm2s_cmd_ready, mm2s_done, s2mm_cmd_ready, s2mm_done
  );

endinterface

// File: rtl/slot_dispatcher_dma_cmd_chan.sv
// One DMA command channel: latches a descriptor, holds valid until ready, and
// tracks accepted/completed with a bypass for zero-length transfers.
module dma_cmd_chan #(
  parameter int ADDR_WIDTH = 32,
  parameter int SIZE_WIDTH = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  active,
  input  logic [ADDR_WIDTH-1:0] desc_addr,
  input  logic [SIZE_WIDTH-1:0] desc_size,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [SIZE_WIDTH-1:0] cmd_size,
  input  logic                  done_in,
  output logic                  accepted,
  output logic                  completed
);

  logic acc_q;
  logic done_q;
  logic bypass;

  assign bypass = (desc_size == '0);

  // Zero-length transfers start out already accepted and completed.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= 1'b0;
      done_q   <= 1'b0;
      cmd_addr <= '0;
      cmd_size <= '0;
    end else if (load) begin
      cmd_addr <= desc_addr;
      cmd_size <= desc_size;
      acc_q    <= bypass;
      done_q   <= bypass;
    end else if (active) begin
      if (cmd_valid && cmd_ready) acc_q  <= 1'b1;
      if (done_in)                done_q <= 1'b1;
    end
  end

  assign cmd_valid = active & ~acc_q;
  // Same-cycle handshake/completion counts, so the FSM advances without an extra cycle.
  assign accepted  = acc_q | (cmd_valid & cmd_ready);
  assign completed = done_q | (active & done_in);

endmodule

// File: rtl/slot_dispatcher.sv
// Walks the slot table in index order, dispatches each PENDING descriptor to the
// MM2S/S2MM command channels, and writes back DONE plus the measured cycle count.
module slot_dispatcher
  import slot_dispatcher_pkg::*;
#(
  parameter int INDEX_WIDTH    = 2,
  parameter int SRC_ADDR_WIDTH = 32,
  parameter int SRC_SIZE_WIDTH = 26,
  parameter int DST_ADDR_WIDTH = 32,
  parameter int DST_SIZE_WIDTH = 26,
  parameter int STATUS_WIDTH   = 2,
  parameter int PROFILE_WIDTH  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  slot_dispatcher_if.master  bus
);

  localparam logic [INDEX_WIDTH-1:0] IDX_LAST = {INDEX_WIDTH{1'b1}};

  state_t                   state;
  state_t                   state_n;
  logic [INDEX_WIDTH-1:0]   idx;
  logic [PROFILE_WIDTH-1:0] profile;
  logic                     done_q;
  logic                     load;
  logic                     active;
  logic                     mm2s_acc;
  logic                     mm2s_cmp;
  logic                     s2mm_acc;
  logic                     s2mm_cmp;

  function automatic logic [PROFILE_WIDTH-1:0] sat_inc(input logic [PROFILE_WIDTH-1:0] v);
    return (&v) ? v : v + PROFILE_WIDTH'(1);
  endfunction

  assign load   = (state == S_FETCH);
  assign active = (state == S_ISSUE) || (state == S_WAIT);

  dma_cmd_chan #(
    .ADDR_WIDTH (SRC_ADDR_WIDTH),
    .SIZE_WIDTH (SRC_SIZE_WIDTH)
  ) u_mm2s (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .active    (active),
    .desc_addr (bus.rd_src_addr),
    .desc_size (bus.rd_src_size),
    .cmd_valid (bus.mm2s_cmd_valid),
    .cmd_ready (bus.mm2s_cmd_ready),
    .cmd_addr  (bus.mm2s_cmd_addr),
    .cmd_size  (bus.mm2s_cmd_size),
    .done_in   (bus.mm2s_done),
    .accepted  (mm2s_acc),
    .completed (mm2s_cmp)
  );

  dma_cmd_chan #(
    .ADDR_WIDTH (DST_ADDR_WIDTH),
    .SIZE_WIDTH (DST_SIZE_WIDTH)
  ) u_s2mm (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .active    (active),
    .desc_addr (bus.rd_des_addr),
    .desc_size (bus.rd_des_size),
    .cmd_valid (bus.s2mm_cmd_valid),
    .cmd_ready (bus.s2mm_cmd_ready),
    .cmd_addr  (bus.s2mm_cmd_addr),
    .cmd_size  (bus.s2mm_cmd_size),
    .done_in   (bus.s2mm_done),
    .accepted  (s2mm_acc),
    .completed (s2mm_cmp)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      idx     <= '0;
      profile <= '0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= (state == S_NEXT) && (idx == IDX_LAST);
      if (state == S_IDLE && start)           idx <= '0;
      else if (state == S_NEXT && idx != IDX_LAST) idx <= idx + INDEX_WIDTH'(1);
      if (state == S_FETCH) profile <= '0;
      else if (active)      profile <= sat_inc(profile);
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_FETCH;
      S_FETCH: state_n = (bus.rd_status == STATUS_WIDTH'(ST_PENDING)) ? S_ISSUE : S_NEXT;
      S_ISSUE: if (mm2s_acc && s2mm_acc) state_n = S_WAIT;
      S_WAIT:  if (mm2s_cmp && s2mm_cmp) state_n = S_WB;
      S_WB:    state_n = S_NEXT;
      S_NEXT:  state_n = (idx == IDX_LAST) ? S_IDLE : S_FETCH;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    bus.set_status  = 1'b0;
    bus.set_profile = 1'b0;
    bus.wr_index    = '0;
    bus.wr_status   = '0;
    bus.wr_profile  = '0;
    if (state == S_WB) begin
      bus.set_status  = 1'b1;
      bus.set_profile = 1'b1;
      bus.wr_index    = idx;
      bus.wr_status   = STATUS_WIDTH'(ST_DONE);
      bus.wr_profile  = profile;
    end
  end

  assign bus.rd_index = idx;
  assign busy         = (state != S_IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_slot_dispatcher.sv
// Directed bench for slot_dispatcher: cycle-exact scenarios against a small table model.
module tb_slot_dispatcher;
  import slot_dispatcher_pkg::*;

  localparam int IW = 2, SAW = 32, SSW = 26, DAW = 32, DSW = 26, STW = 2, PW = 32;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;

  slot_dispatcher_if #(.INDEX_WIDTH(IW), .SRC_ADDR_WIDTH(SAW), .SRC_SIZE_WIDTH(SSW),
    .DST_ADDR_WIDTH(DAW), .DST_SIZE_WIDTH(DSW), .STATUS_WIDTH(STW), .PROFILE_WIDTH(PW)) bus ();

  slot_dispatcher #(.INDEX_WIDTH(IW), .SRC_ADDR_WIDTH(SAW), .SRC_SIZE_WIDTH(SSW),
    .DST_ADDR_WIDTH(DAW), .DST_SIZE_WIDTH(DSW), .STATUS_WIDTH(STW), .PROFILE_WIDTH(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [SAW-1:0] t_src_addr [4];
  logic [SSW-1:0] t_src_size [4];
  logic [DAW-1:0] t_des_addr [4];
  logic [DSW-1:0] t_des_size [4];
  logic [STW-1:0] t_status   [4];

  assign bus.rd_src_addr = t_src_addr[bus.rd_index];
  assign bus.rd_src_size = t_src_size[bus.rd_index];
  assign bus.rd_des_addr = t_des_addr[bus.rd_index];
  assign bus.rd_des_size = t_des_size[bus.rd_index];
  assign bus.rd_status   = t_status[bus.rd_index];

  int wb_cnt = 0, mm_vld_cnt = 0, s2_vld_cnt = 0;
  always @(negedge clk) begin
    if (bus.set_status)     wb_cnt     <= wb_cnt + 1;
    if (bus.mm2s_cmd_valid) mm_vld_cnt <= mm_vld_cnt + 1;
    if (bus.s2mm_cmd_valid) s2_vld_cnt <= s2_vld_cnt + 1;
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_table();
    for (int i = 0; i < 4; i++) begin
      t_src_addr[i] = '0; t_src_size[i] = '0;
      t_des_addr[i] = '0; t_des_size[i] = '0;
      t_status[i]   = ST_EMPTY;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    bus.mm2s_cmd_ready = 1'b0; bus.s2mm_cmd_ready = 1'b0;
    bus.mm2s_done = 1'b0; bus.s2mm_done = 1'b0;
    clear_table();
    t_src_addr[0] = 32'hDEAD_BEEF; t_src_size[0] = 26'd5; t_status[0] = ST_PENDING;
    repeat (3) step();
    vec_cnt++;
    if ({busy, done, bus.mm2s_cmd_valid, bus.s2mm_cmd_valid, bus.set_status, bus.set_profile} !== 6'b0) begin
      err_cnt++;
      $display("FAIL reset_ctrl: got %b expected 000000", {busy, done, bus.mm2s_cmd_valid,
               bus.s2mm_cmd_valid, bus.set_status, bus.set_profile});
    end
    vec_cnt++;
    if ({bus.rd_index, bus.wr_index, bus.wr_status, bus.wr_profile} !== '0) begin
      err_cnt++;
      $display("FAIL reset_table: rd_index=%0d wr_index=%0d wr_status=%0d wr_profile=%0d expected all 0",
               bus.rd_index, bus.wr_index, bus.wr_status, bus.wr_profile);
    end
    vec_cnt++;
    if ({bus.mm2s_cmd_addr, bus.mm2s_cmd_size, bus.s2mm_cmd_addr, bus.s2mm_cmd_size} !== '0) begin
      err_cnt++;
      $display("FAIL reset_cmd: mm2s %h/%0d s2mm %h/%0d expected all 0", bus.mm2s_cmd_addr,
               bus.mm2s_cmd_size, bus.s2mm_cmd_addr, bus.s2mm_cmd_size);
    end
    reset = 1'b0;
    clear_table();
    step();
  endtask

  task automatic test_all_empty();
    int wb0, mm0, s20, done_at, done_hi;
    clear_table();
    bus.mm2s_cmd_ready = 1'b1; bus.s2mm_cmd_ready = 1'b1;
    wb0 = wb_cnt; mm0 = mm_vld_cnt; s20 = s2_vld_cnt; done_at = -1; done_hi = 0;
    start = 1'b1; step(); start = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      if (n == 1) begin
        vec_cnt++;
        if (busy !== 1'b1) begin err_cnt++; $display("FAIL empty_busy_c1: busy=%b expected 1", busy); end
      end
      if (n == 9) begin
        vec_cnt++;
        if (busy !== 1'b0) begin err_cnt++; $display("FAIL empty_busy_c9: busy=%b expected 0", busy); end
      end
      if (done === 1'b1) begin
        done_hi++;
        if (done_at < 0) done_at = n;
      end
      step();
    end
    vec_cnt++;
    if (done_at !== 9) begin err_cnt++; $display("FAIL empty_done_cycle: got %0d expected 9", done_at); end
    vec_cnt++;
    if (done_hi !== 1) begin err_cnt++; $display("FAIL empty_done_width: got %0d expected 1", done_hi); end
    vec_cnt++;
    if (wb_cnt - wb0 !== 0) begin err_cnt++; $display("FAIL empty_writes: got %0d expected 0", wb_cnt - wb0); end
    vec_cnt++;
    if ((mm_vld_cnt - mm0) + (s2_vld_cnt - s20) !== 0) begin
      err_cnt++;
      $display("FAIL empty_valids: got %0d expected 0", (mm_vld_cnt - mm0) + (s2_vld_cnt - s20));
    end
  endtask

  task automatic test_pending_slot();
    int wb0, done_at;
    clear_table();
    t_src_addr[2] = 32'h1000; t_src_size[2] = 26'd64;
    t_des_addr[2] = 32'h2000; t_des_size[2] = 26'd64; t_status[2] = ST_PENDING;
    bus.mm2s_cmd_ready = 1'b1; bus.s2mm_cmd_ready = 1'b1;
    wb0 = wb_cnt; done_at = -1;
    start = 1'b1; step(); start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (n == 6) begin
        vec_cnt++;
        if ({bus.mm2s_cmd_valid, bus.mm2s_cmd_addr, bus.mm2s_cmd_size, bus.s2mm_cmd_valid,
             bus.s2mm_cmd_addr, bus.s2mm_cmd_size} !== {1'b1, 32'h1000, 26'd64, 1'b1, 32'h2000, 26'd64}) begin
          err_cnt++;
          $display("FAIL pend_issue: mm2s v=%b %h/%0d s2mm v=%b %h/%0d expected 1 1000/64 1 2000/64",
                   bus.mm2s_cmd_valid, bus.mm2s_cmd_addr, bus.mm2s_cmd_size,
                   bus.s2mm_cmd_valid, bus.s2mm_cmd_addr, bus.s2mm_cmd_size);
        end
      end
      if (n == 13) begin
        vec_cnt++;
        if ({bus.set_status, bus.set_profile, bus.wr_index, bus.wr_status, bus.wr_profile} !==
            {1'b1, 1'b1, 2'd2, 2'b10, 32'd7}) begin
          err_cnt++;
          $display("FAIL pend_wb: set=%b%b idx=%0d status=%b profile=%0d expected 11 2 10 7",
                   bus.set_status, bus.set_profile, bus.wr_index, bus.wr_status, bus.wr_profile);
        end
      end
      if (done === 1'b1 && done_at < 0) done_at = n;
      bus.mm2s_done = (n == 9);
      bus.s2mm_done = (n == 12);
      step();
    end
    bus.mm2s_done = 1'b0; bus.s2mm_done = 1'b0;
    vec_cnt++;
    if (wb_cnt - wb0 !== 1) begin err_cnt++; $display("FAIL pend_writes: got %0d expected 1", wb_cnt - wb0); end
    vec_cnt++;
    if (done_at !== 17) begin err_cnt++; $display("FAIL pend_done_cycle: got %0d expected 17", done_at); end
  endtask

  task automatic test_ready_stall();
    int done_at;
    clear_table();
    t_src_addr[1] = 32'h3000; t_src_size[1] = 26'd128;
    t_des_addr[1] = 32'h4000; t_des_size[1] = 26'd128; t_status[1] = ST_PENDING;
    bus.mm2s_cmd_ready = 1'b0; bus.s2mm_cmd_ready = 1'b1;
    done_at = -1;
    start = 1'b1; step(); start = 1'b0;
    for (int n = 1; n <= 22; n++) begin
      if (n >= 4 && n <= 8) begin
        vec_cnt++;
        if ({bus.mm2s_cmd_valid, bus.mm2s_cmd_addr, bus.mm2s_cmd_size} !== {1'b1, 32'h3000, 26'd128}) begin
          err_cnt++;
          $display("FAIL stall_hold_c%0d: v=%b %h/%0d expected 1 3000/128", n,
                   bus.mm2s_cmd_valid, bus.mm2s_cmd_addr, bus.mm2s_cmd_size);
        end
      end
      if (n == 9) begin
        vec_cnt++;
        if (bus.mm2s_cmd_valid !== 1'b0) begin
          err_cnt++; $display("FAIL stall_drop: mm2s valid=%b expected 0", bus.mm2s_cmd_valid);
        end
      end
      if (n == 5) begin
        vec_cnt++;
        if (bus.s2mm_cmd_valid !== 1'b0) begin
          err_cnt++; $display("FAIL stall_s2mm_indep: s2mm valid=%b expected 0", bus.s2mm_cmd_valid);
        end
      end
      if (n == 12) begin
        vec_cnt++;
        if ({bus.set_status, bus.wr_index, bus.wr_profile} !== {1'b1, 2'd1, 32'd8}) begin
          err_cnt++;
          $display("FAIL stall_wb: set=%b idx=%0d profile=%0d expected 1 1 8",
                   bus.set_status, bus.wr_index, bus.wr_profile);
        end
      end
      if (done === 1'b1 && done_at < 0) done_at = n;
      bus.mm2s_cmd_ready = (n >= 8);
      bus.s2mm_done = (n == 6);
      bus.mm2s_done = (n == 11);
      step();
    end
    bus.mm2s_done = 1'b0; bus.s2mm_done = 1'b0; bus.mm2s_cmd_ready = 1'b1;
    vec_cnt++;
    if (done_at !== 18) begin err_cnt++; $display("FAIL stall_done_cycle: got %0d expected 18", done_at); end
  endtask

  task automatic test_zero_size();
    int mm0, done_at;
    clear_table();
    t_src_addr[0] = 32'h5000; t_src_size[0] = 26'd0;
    t_des_addr[0] = 32'h6000; t_des_size[0] = 26'd32; t_status[0] = ST_PENDING;
    bus.mm2s_cmd_ready = 1'b1; bus.s2mm_cmd_ready = 1'b1;
    mm0 = mm_vld_cnt; done_at = -1;
    start = 1'b1; step(); start = 1'b0;
    for (int n = 1; n <= 18; n++) begin
      if (n == 2) begin
        vec_cnt++;
        if ({bus.s2mm_cmd_valid, bus.s2mm_cmd_addr, bus.s2mm_cmd_size} !== {1'b1, 32'h6000, 26'd32}) begin
          err_cnt++;
          $display("FAIL zero_s2mm_issue: v=%b %h/%0d expected 1 6000/32",
                   bus.s2mm_cmd_valid, bus.s2mm_cmd_addr, bus.s2mm_cmd_size);
        end
      end
      if (n == 6) begin
        vec_cnt++;
        if ({bus.set_status, bus.wr_index, bus.wr_profile} !== {1'b1, 2'd0, 32'd4}) begin
          err_cnt++;
          $display("FAIL zero_wb: set=%b idx=%0d profile=%0d expected 1 0 4",
                   bus.set_status, bus.wr_index, bus.wr_profile);
        end
      end
      if (done === 1'b1 && done_at < 0) done_at = n;
      bus.s2mm_done = (n == 5);
      step();
    end
    bus.s2mm_done = 1'b0;
    vec_cnt++;
    if (mm_vld_cnt - mm0 !== 0) begin
      err_cnt++; $display("FAIL zero_no_mm2s: valid cycles=%0d expected 0", mm_vld_cnt - mm0);
    end
    vec_cnt++;
    if (done_at !== 14) begin err_cnt++; $display("FAIL zero_done_cycle: got %0d expected 14", done_at); end
  endtask

  task automatic test_reset_in_wait();
    int wb0, done_at;
    clear_table();
    t_src_addr[0] = 32'h7000; t_src_size[0] = 26'd16;
    t_des_addr[0] = 32'h8000; t_des_size[0] = 26'd16; t_status[0] = ST_PENDING;
    bus.mm2s_cmd_ready = 1'b1; bus.s2mm_cmd_ready = 1'b1;
    wb0 = wb_cnt;
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    reset = 1'b1; step(); reset = 1'b0;
    vec_cnt++;
    if ({busy, bus.mm2s_cmd_valid, bus.s2mm_cmd_valid, bus.set_status} !== 4'b0) begin
      err_cnt++;
      $display("FAIL rstwait_idle: busy=%b valids=%b%b set_status=%b expected 0 00 0",
               busy, bus.mm2s_cmd_valid, bus.s2mm_cmd_valid, bus.set_status);
    end
    repeat (4) step();
    vec_cnt++;
    if (wb_cnt - wb0 !== 0) begin err_cnt++; $display("FAIL rstwait_no_wb: got %0d expected 0", wb_cnt - wb0); end
    done_at = -1;
    start = 1'b1; step(); start = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      if (n == 4) begin
        vec_cnt++;
        if ({bus.set_status, bus.wr_index, bus.wr_status, bus.wr_profile} !== {1'b1, 2'd0, 2'b10, 32'd2}) begin
          err_cnt++;
          $display("FAIL rstwait_rerun_wb: set=%b idx=%0d status=%b profile=%0d expected 1 0 10 2",
                   bus.set_status, bus.wr_index, bus.wr_status, bus.wr_profile);
        end
      end
      if (done === 1'b1 && done_at < 0) done_at = n;
      bus.mm2s_done = (n == 3);
      bus.s2mm_done = (n == 3);
      step();
    end
    bus.mm2s_done = 1'b0; bus.s2mm_done = 1'b0;
    vec_cnt++;
    if (done_at !== 12) begin err_cnt++; $display("FAIL rstwait_done_cycle: got %0d expected 12", done_at); end
  endtask

  task automatic test_busy_start_and_reserved();
    int wb0, done_at;
    clear_table();
    t_src_addr[1] = 32'h9000; t_src_size[1] = 26'd8;
    t_des_addr[1] = 32'hA000; t_des_size[1] = 26'd8; t_status[1] = ST_RSVD;
    t_src_addr[3] = 32'hB000; t_src_size[3] = 26'd8;
    t_des_addr[3] = 32'hC000; t_des_size[3] = 26'd8; t_status[3] = ST_PENDING;
    bus.mm2s_cmd_ready = 1'b1; bus.s2mm_cmd_ready = 1'b1;
    wb0 = wb_cnt; done_at = -1;
    start = 1'b1; step(); start = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      if (n == 10) begin
        vec_cnt++;
        if ({bus.set_status, bus.wr_index, bus.wr_profile} !== {1'b1, 2'd3, 32'd2}) begin
          err_cnt++;
          $display("FAIL busy_wb: set=%b idx=%0d profile=%0d expected 1 3 2",
                   bus.set_status, bus.wr_index, bus.wr_profile);
        end
      end
      if (n >= 12 && n <= 14) begin
        vec_cnt++;
        if (busy !== 1'b0) begin err_cnt++; $display("FAIL busy_restart_c%0d: busy=%b expected 0", n, busy); end
      end
      if (done === 1'b1 && done_at < 0) done_at = n;
      start = (n == 3) || (n == 11);
      bus.mm2s_done = (n == 9);
      bus.s2mm_done = (n == 9);
      step();
    end
    start = 1'b0; bus.mm2s_done = 1'b0; bus.s2mm_done = 1'b0;
    vec_cnt++;
    if (wb_cnt - wb0 !== 1) begin err_cnt++; $display("FAIL busy_writes: got %0d expected 1", wb_cnt - wb0); end
    vec_cnt++;
    if (done_at !== 12) begin err_cnt++; $display("FAIL busy_done_cycle: got %0d expected 12", done_at); end
  endtask

  initial begin
    test_reset();
    test_all_empty();
    test_pending_slot();
    test_ready_stall();
    test_zero_size();
    test_reset_in_wait();
    test_busy_start_and_reserved();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1);
  end

endmodule
